// File: rtl/barrel_scheduler.sv
// Kong barrel launch controller: arbitrates horizontal/vertical throw
// requests, sequences the throw pose and assigns each launch a free slot.
module barrel_scheduler #(
    parameter int BARRELS      = 5,
    parameter int AUTO_DELAY   = 162_500_000,
    parameter int THROW_CYCLES = 4_062_500,
    parameter int COOLDOWN     = 1_625_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_game,
    input  logic               animation,
    input  logic               key_hor,
    input  logic               key_ver,
    input  logic [BARRELS-1:0] done_hor,
    input  logic [BARRELS-1:0] done_ver,
    output logic [BARRELS-1:0] barrel_hor,
    output logic [BARRELS-1:0] barrel_ver,
    output logic               throw,
    output logic               busy,
    output logic               last_ver
);

    localparam int TW   = (AUTO_DELAY > 1) ? $clog2(AUTO_DELAY) : 1;
    localparam int PMAX = (THROW_CYCLES > COOLDOWN) ? THROW_CYCLES : COOLDOWN;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int SW   = (BARRELS > 1) ? $clog2(BARRELS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] THROW = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    localparam logic [TW-1:0]      TIMER_LAST = TW'(AUTO_DELAY - 1);
    localparam logic [PW-1:0]      THROW_LAST = PW'(THROW_CYCLES - 1);
    localparam logic [PW-1:0]      COOL_LAST  = PW'(COOLDOWN - 1);
    localparam logic [BARRELS-1:0] ONE        = BARRELS'(1);

    logic [1:0]         state;
    logic [PW-1:0]      phase_cnt;
    logic [TW-1:0]      timer;
    logic               req_hor;
    logic               req_ver;
    logic               key_hor_q;
    logic               key_ver_q;
    logic [SW-1:0]      slot;

    logic               en;
    logic               hor_rise;
    logic               ver_rise;
    logic               expire;
    logic               elig_hor;
    logic               elig_ver;
    logic               grant;
    logic               win_ver;
    logic [BARRELS-1:0] free_win;
    logic [SW-1:0]      first_free;
    logic               throw_end;
    logic               cool_end;
    logic [BARRELS-1:0] set_hor;
    logic [BARRELS-1:0] set_ver;

    assign en       = start_game & ~animation;
    assign hor_rise = key_hor & ~key_hor_q;
    assign ver_rise = key_ver & ~key_ver_q;
    assign expire   = en && (timer == TIMER_LAST);

    assign elig_hor = req_hor & (|(~barrel_hor));
    assign elig_ver = req_ver & (|(~barrel_ver));
    assign grant    = en && (state == IDLE) && (elig_hor || elig_ver);

    // On a tie the class opposite to the previous grant wins.
    assign win_ver  = elig_ver & (~elig_hor | ~last_ver);
    assign free_win = win_ver ? ~barrel_ver : ~barrel_hor;

    always_comb begin
        first_free = '0;
        for (int i = BARRELS - 1; i >= 0; i--) begin
            if (free_win[i]) first_free = SW'(i);
        end
    end

    assign throw_end = en && (state == THROW) && (phase_cnt == THROW_LAST);
    assign cool_end  = en && (state == COOL) && (phase_cnt == COOL_LAST);

    // last_ver holds the class of the launch in flight.
    assign set_hor = (throw_end && !last_ver) ? (ONE << slot) : '0;
    assign set_ver = (throw_end && last_ver) ? (ONE << slot) : '0;

    assign throw = (state == THROW);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            timer      <= '0;
            req_hor    <= 1'b0;
            req_ver    <= 1'b0;
            key_hor_q  <= 1'b0;
            key_ver_q  <= 1'b0;
            slot       <= '0;
            last_ver   <= 1'b1;
            barrel_hor <= '0;
            barrel_ver <= '0;
        end else if (!start_game) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            timer      <= '0;
            req_hor    <= 1'b0;
            req_ver    <= 1'b0;
            key_hor_q  <= 1'b0;
            key_ver_q  <= 1'b0;
            barrel_hor <= '0;
            barrel_ver <= '0;
        end else begin
            key_hor_q  <= key_hor;
            key_ver_q  <= key_ver;
            barrel_hor <= (barrel_hor & ~done_hor) | set_hor;
            barrel_ver <= (barrel_ver & ~done_ver) | set_ver;
            if (animation) begin
                state     <= IDLE;
                phase_cnt <= '0;
            end else begin
                timer <= expire ? '0 : timer + 1'b1;
                if (hor_rise || expire) req_hor <= 1'b1;
                if (ver_rise) req_ver <= 1'b1;
                case (state)
                    IDLE: begin
                        phase_cnt <= '0;
                        if (grant) begin
                            state    <= THROW;
                            slot     <= first_free;
                            last_ver <= win_ver;
                        end
                    end
                    THROW: begin
                        if (throw_end) begin
                            state     <= COOL;
                            phase_cnt <= '0;
                            if (last_ver) req_ver <= 1'b0;
                            else          req_hor <= 1'b0;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    COOL: begin
                        if (cool_end) begin
                            state     <= IDLE;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Scoreboard bench for barrel_scheduler: expected launches and slot-vector
// changes are queued by the stimulus and popped by a negedge monitor.
module tb_barrel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_game;
    logic       animation;
    logic       key_hor;
    logic       key_ver;
    logic [1:0] done_hor;
    logic [1:0] done_ver;
    logic [1:0] barrel_hor;
    logic [1:0] barrel_ver;
    logic       throw;
    logic       busy;
    logic       last_ver;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic ver;
    } launch_t;

    typedef struct {
        int         cyc;
        logic [1:0] hor;
        logic [1:0] ver;
    } vec_t;

    launch_t lq[$];
    vec_t    vq[$];

    logic       throw_q = 1'b0;
    logic [3:0] vec_q   = 4'b0;

    barrel_scheduler #(
        .BARRELS(2),
        .AUTO_DELAY(50),
        .THROW_CYCLES(3),
        .COOLDOWN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_game(start_game),
        .animation(animation),
        .key_hor(key_hor),
        .key_ver(key_ver),
        .done_hor(done_hor),
        .done_ver(done_ver),
        .barrel_hor(barrel_hor),
        .barrel_ver(barrel_ver),
        .throw(throw),
        .busy(busy),
        .last_ver(last_ver)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every throw rise and every slot-vector change must match
    // the next queued expectation.
    always @(negedge clk) begin
        launch_t l;
        vec_t    v;
        if (throw === 1'b1 && throw_q === 1'b0) begin
            checks++;
            if (lq.size() == 0) begin
                errors++;
                $display("FAIL launch: unexpected throw at cycle %0d", cyc);
            end else begin
                l = lq.pop_front();
                if (l.cyc != cyc || l.ver !== last_ver) begin
                    errors++;
                    $display("FAIL launch: got cycle %0d ver %b, expected cycle %0d ver %b",
                             cyc, last_ver, l.cyc, l.ver);
                end
            end
        end
        if ({barrel_hor, barrel_ver} !== vec_q) begin
            checks++;
            if (vq.size() == 0) begin
                errors++;
                $display("FAIL slots: unexpected change hor=%b ver=%b at cycle %0d",
                         barrel_hor, barrel_ver, cyc);
            end else begin
                v = vq.pop_front();
                if (v.cyc != cyc || v.hor !== barrel_hor || v.ver !== barrel_ver) begin
                    errors++;
                    $display("FAIL slots: got cycle %0d hor=%b ver=%b, expected cycle %0d hor=%b ver=%b",
                             cyc, barrel_hor, barrel_ver, v.cyc, v.hor, v.ver);
                end
            end
        end
        throw_q <= throw;
        vec_q   <= {barrel_hor, barrel_ver};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic exp_launch(input int c, input logic v);
        launch_t l;
        l.cyc = c;
        l.ver = v;
        lq.push_back(l);
    endtask

    task automatic exp_vec(input int c, input logic [1:0] h, input logic [1:0] v);
        vec_t e;
        e.cyc = c;
        e.hor = h;
        e.ver = v;
        vq.push_back(e);
    endtask

    task automatic reset_and_start(output int s);
        rst        = 1'b1;
        start_game = 1'b0;
        animation  = 1'b0;
        key_hor    = 1'b0;
        key_ver    = 1'b0;
        done_hor   = 2'b00;
        done_ver   = 2'b00;
        tick(2);
        chk("rst_throw", 32'(throw), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_ver", 32'(last_ver), 32'd1);
        chk("rst_vectors", 32'({barrel_hor, barrel_ver}), 32'd0);
        rst        = 1'b0;
        start_game = 1'b1;
        s = cyc;
    endtask

    initial begin
        int s;

        // Auto timer launch
        reset_and_start(s);
        exp_launch(s + 51, 1'b0);
        exp_vec(s + 54, 2'b01, 2'b00);
        wait_until(s + 55);
        chk("auto_busy_cool", 32'(busy), 32'd1);
        wait_until(s + 56);
        chk("auto_busy_idle", 32'(busy), 32'd0);
        wait_until(s + 60);
        start_game = 1'b0;
        exp_vec(s + 61, 2'b00, 2'b00);
        tick(3);

        // Simultaneous requests: horizontal first, vertical after cooldown
        reset_and_start(s);
        key_hor = 1'b1;
        key_ver = 1'b1;
        exp_launch(s + 2, 1'b0);
        exp_vec(s + 5, 2'b01, 2'b00);
        exp_launch(s + 8, 1'b1);
        exp_vec(s + 11, 2'b01, 2'b01);
        tick(1);
        key_hor = 1'b0;
        key_ver = 1'b0;
        wait_until(s + 5);
        chk("tie_last_ver_hor", 32'(last_ver), 32'd0);
        wait_until(s + 12);
        chk("tie_last_ver_ver", 32'(last_ver), 32'd1);
        wait_until(s + 15);
        start_game = 1'b0;
        exp_vec(s + 16, 2'b00, 2'b00);
        tick(3);

        // Vertical pool fills, third request waits for a free slot
        reset_and_start(s);
        key_ver = 1'b1;
        exp_launch(s + 2, 1'b1);
        exp_vec(s + 5, 2'b00, 2'b01);
        exp_launch(s + 10, 1'b1);
        exp_vec(s + 13, 2'b00, 2'b11);
        exp_vec(s + 23, 2'b00, 2'b01);
        exp_launch(s + 24, 1'b1);
        exp_vec(s + 27, 2'b00, 2'b11);
        tick(1);
        key_ver = 1'b0;
        wait_until(s + 8);
        key_ver = 1'b1;
        tick(1);
        key_ver = 1'b0;
        wait_until(s + 16);
        key_ver = 1'b1;
        tick(1);
        key_ver = 1'b0;
        wait_until(s + 20);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_throw", 32'(throw), 32'd0);
        wait_until(s + 22);
        done_ver = 2'b10;
        tick(1);
        done_ver = 2'b00;
        wait_until(s + 30);
        start_game = 1'b0;
        exp_vec(s + 31, 2'b00, 2'b00);
        tick(3);

        // Animation freezes timer and ignores keys
        reset_and_start(s);
        animation = 1'b1;
        wait_until(s + 2);
        key_ver = 1'b1;
        tick(1);
        key_ver = 1'b0;
        wait_until(s + 5);
        chk("anim_throw", 32'(throw), 32'd0);
        wait_until(s + 10);
        animation = 1'b0;
        exp_launch(s + 61, 1'b0);
        exp_vec(s + 64, 2'b01, 2'b00);
        wait_until(s + 66);
        start_game = 1'b0;
        exp_vec(s + 67, 2'b00, 2'b00);
        tick(3);

        // start_game drops during the second throw cycle
        reset_and_start(s);
        key_hor = 1'b1;
        exp_launch(s + 2, 1'b0);
        tick(1);
        key_hor = 1'b0;
        wait_until(s + 3);
        start_game = 1'b0;
        wait_until(s + 4);
        chk("abort_throw", 32'(throw), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vectors", 32'({barrel_hor, barrel_ver}), 32'd0);
        wait_until(s + 10);
        chk("abort_no_slot", 32'({barrel_hor, barrel_ver}), 32'd0);

        // done handling on inactive and active slots
        reset_and_start(s);
        done_hor = 2'b01;
        tick(1);
        done_hor = 2'b00;
        wait_until(s + 2);
        chk("done_idle_slots", 32'(barrel_hor), 32'd0);
        key_hor = 1'b1;
        exp_launch(s + 4, 1'b0);
        exp_vec(s + 7, 2'b01, 2'b00);
        exp_launch(s + 12, 1'b0);
        exp_vec(s + 15, 2'b11, 2'b00);
        exp_vec(s + 18, 2'b10, 2'b00);
        tick(1);
        key_hor = 1'b0;
        wait_until(s + 10);
        key_hor = 1'b1;
        tick(1);
        key_hor = 1'b0;
        wait_until(s + 17);
        done_hor = 2'b01;
        tick(1);
        done_hor = 2'b00;
        wait_until(s + 20);
        done_hor = 2'b01;
        tick(1);
        done_hor = 2'b00;
        wait_until(s + 22);
        chk("done_hor_final", 32'(barrel_hor), 32'h2);
        start_game = 1'b0;
        exp_vec(s + 23, 2'b00, 2'b00);
        tick(4);

        chk("launch_queue_empty", 32'(lq.size()), 32'd0);
        chk("slot_queue_empty", 32'(vq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
